mem_stage_ws: RTL and testbench
===============================

# mem_stage_ws

Parametrised pipeline memory stage with wait-state support. Sits between EX and WB like the single-cycle memory stage it replaces, but adds a configurable-latency internal data RAM, a stall handshake back to the pipeline, byte-lane stores and loads at any legal byte offset, and alignment/range fault detection. Writeback control fields (en_wb, pcp4, use_pcp4, reg_write) travel with each access and emerge together with its result.

## Interface
Parameters:
- XLEN, 32, datapath width; only 32 is supported.
- DEPTH, 64, RAM depth in XLEN-bit words; must be a power of two.
- WAIT, 2, extra cycles per memory access; legal range 0..15.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- en  in  1  request is a memory access; 0 means pass-through op.
- write  in  1  1 = store, 0 = load (used only when en=1).
- addr  in  XLEN  effective byte address, or pass-through value when en=0.
- write_data  in  XLEN  store data, right-aligned.
- size  in  2  `SIZE_8`=0, `SIZE_16`=1, `SIZE_32`=2; 3 is illegal.
- load_unsigned  in  1  zero-extend narrow loads when 1, sign-extend when 0.
- en_wb, use_pcp4  in  1  writeback controls, carried through the stage.
- pcp4  in  XLEN  PC+4, carried through the stage.
- reg_write  in  5  destination register, carried through the stage.
- read_data  out  XLEN  load result, pass-through addr, or 0.
- en_wb_out, use_pcp4_out  out  1  carried controls; en_wb_out is forced to 0 on a fault.
- pcp4_out  out  XLEN  carried PC+4.
- reg_write_out  out  5  carried destination register.
- valid_out  out  1  one-cycle pulse: outputs hold a completed op.
- stall  out  1  stage busy; upstream must not advance.
- fault  out  1  one-cycle pulse with valid_out: the access was illegal.

## Operation
- FSM states: IDLE, BUSY.
- IDLE: a request is accepted on every rising edge. All inputs are captured into request registers.
  - en=0: read_data<=addr. Carried fields are copied. valid_out=1. State stays IDLE.
  - en=1 and illegal: fault=1, valid_out=1, en_wb_out=0, read_data=0. There is no RAM access and no write. State stays IDLE. An access is illegal when any of these holds:
    - size=3;
    - size=1 and addr[0]=1;
    - size=2 and addr[1:0]!=0;
    - word index addr>>2 ≥ DEPTH.
  - en=1 and legal with WAIT=0: the access completes on the same edge. State stays IDLE.
  - en=1 and legal with WAIT>0: load wait counter with WAIT−1 and go to BUSY.
- BUSY: stall=1. Inputs are ignored. The counter decrements each cycle. On the edge where the counter is 0 the access is performed, outputs are registered, valid_out=1, and state returns to IDLE.
- Store, little-endian byte lanes:
  - size=0 writes byte lane addr[1:0] with write_data[7:0].
  - size=1 writes lanes {addr[1],0} and {addr[1],1} with write_data[15:0].
  - size=2 writes the whole word.
  - Other bytes of the word are unchanged. read_data=0 for stores.
- Load: the RAM word is shifted right by 8·addr[1:0]. Bits [7:0] or [15:0] are then sign- or zero-extended per load_unsigned. A word load returns the word unchanged.
- Carried fields always come from the captured request, never from live inputs.
- valid_out and fault are 0 on every cycle except a completion edge.

## Timing
- stall is combinational from state: stall = (state==BUSY).
- Request accepted at edge N:
  - pass-through, fault, or WAIT=0: outputs valid after edge N+1... more precisely, updated on edge N itself and valid during cycle N→N+1.
  - WAIT=k, legal access: stall=1 for cycles N→N+k. Completion edge is N+k, with outputs valid during cycle N+k→N+k+1.
- Outputs other than the pulses (valid_out, fault) hold their values until the next completion edge.
- Reset:
  - All outputs go to 0 and state to IDLE immediately, without waiting for a clock edge.
  - RAM contents are not reset.
  - Reset during BUSY aborts the access. A pending store is not written.
- Back-to-back requests in IDLE complete one per cycle with no bubble.

## Test plan
- WAIT=0, SW 0xDEADBEEF @0x10, then LW @0x10 → valid_out on each accept edge; read_data=0xDEADBEEF; stall never asserted.
- WAIT=3, LB @0x11 after storing word 0x0000_80FF @0x10 → stall high for 3 cycles; on completion read_data=0xFFFFFF80; with load_unsigned=1 read_data=0x00000080; reg_write_out and pcp4_out match the request.
- SB 0xAA @0x12 and SH 0x1234 @0x14 over zeroed words → LW @0x10 = 0x00AA0000 and LW @0x14 = 0x00001234.
- LH @0x13, LW @0x12, size=3, LW @DEPTH·4 → each gives fault=1, valid_out=1, en_wb_out=0, no stall; the RAM is unchanged.
- en=0, addr=0x1234_5678 → read_data=0x12345678 one cycle later, with carried fields passed through.
- WAIT=4, SW 0x55 @0x20; assert rst in the second BUSY cycle → all outputs 0 at once, state IDLE; a later LW @0x20 returns the old value.

Source files
------------

// File: rtl/mem_stage_ws.sv
// Pipeline memory stage with a configurable-latency internal data RAM, stall handshake,
// byte-lane loads/stores and alignment/range fault detection.
module mem_stage_ws #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 64,
  parameter int WAIT  = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic            write,
  input  logic [XLEN-1:0] addr,
  input  logic [XLEN-1:0] write_data,
  input  logic [1:0]      size,
  input  logic            load_unsigned,
  input  logic            en_wb,
  input  logic            use_pcp4,
  input  logic [XLEN-1:0] pcp4,
  input  logic [4:0]      reg_write,
  output logic [XLEN-1:0] read_data,
  output logic            en_wb_out,
  output logic            use_pcp4_out,
  output logic [XLEN-1:0] pcp4_out,
  output logic [4:0]      reg_write_out,
  output logic            valid_out,
  output logic            stall,
  output logic            fault
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t r_state, w_state_nxt;

  logic            r_en, r_write, r_lu, r_en_wb, r_use_pcp4;
  logic [XLEN-1:0] r_addr, r_wdata, r_pcp4;
  logic [1:0]      r_size;
  logic [4:0]      r_reg_write;
  logic [3:0]      r_cnt;
  logic [XLEN-1:0] r_mem [DEPTH];

  logic            w_en, w_write, w_lu, w_en_wb, w_use_pcp4;
  logic [XLEN-1:0] w_addr, w_wdata, w_pcp4;
  logic [1:0]      w_size;
  logic [4:0]      w_reg_write;
  logic            w_misaligned, w_legal, w_complete, w_start, w_mem_we;
  logic [AW-1:0]   w_idx;
  logic [XLEN-1:0] w_rword, w_shifted, w_load, w_lane;
  logic [3:0]      w_be;

  // One access path serves both the same-edge (IDLE) and the delayed (BUSY) completion:
  // IDLE sees the live request, BUSY sees the captured one.
  always_comb begin
    if (r_state == IDLE) begin
      w_en        = en;
      w_write     = write;
      w_addr      = addr;
      w_wdata     = write_data;
      w_size      = size;
      w_lu        = load_unsigned;
      w_en_wb     = en_wb;
      w_use_pcp4  = use_pcp4;
      w_pcp4      = pcp4;
      w_reg_write = reg_write;
    end else begin
      w_en        = r_en;
      w_write     = r_write;
      w_addr      = r_addr;
      w_wdata     = r_wdata;
      w_size      = r_size;
      w_lu        = r_lu;
      w_en_wb     = r_en_wb;
      w_use_pcp4  = r_use_pcp4;
      w_pcp4      = r_pcp4;
      w_reg_write = r_reg_write;
    end
  end

  always_comb begin
    w_misaligned = 1'b0;
    unique case (w_size)
      2'd0:    w_misaligned = 1'b0;
      2'd1:    w_misaligned = w_addr[0];
      2'd2:    w_misaligned = |w_addr[1:0];
      default: w_misaligned = 1'b1;
    endcase
    w_legal = !w_misaligned && (w_addr[XLEN-1:2] < (XLEN-2)'(DEPTH));
  end

  assign w_idx     = w_addr[AW+1:2];
  assign w_rword   = r_mem[w_idx];
  assign w_shifted = w_rword >> {w_addr[1:0], 3'b000};

  always_comb begin
    w_load = w_rword;
    w_be   = 4'b1111;
    w_lane = w_wdata;
    unique case (w_size)
      2'd0: begin
        w_load = {{(XLEN-8){~w_lu & w_shifted[7]}}, w_shifted[7:0]};
        w_be   = 4'b0001 << w_addr[1:0];
        w_lane = {4{w_wdata[7:0]}};
      end
      2'd1: begin
        w_load = {{(XLEN-16){~w_lu & w_shifted[15]}}, w_shifted[15:0]};
        w_be   = w_addr[1] ? 4'b1100 : 4'b0011;
        w_lane = {2{w_wdata[15:0]}};
      end
      default: begin
        w_load = w_rword;
        w_be   = 4'b1111;
        w_lane = w_wdata;
      end
    endcase
  end

  always_comb begin
    w_state_nxt = r_state;
    w_complete  = 1'b0;
    w_start     = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (en && w_legal && (WAIT != 0)) begin
          w_state_nxt = BUSY;
          w_start     = 1'b1;
        end else begin
          w_complete  = 1'b1;
        end
      end
      BUSY: begin
        if (r_cnt == '0) begin
          w_complete  = 1'b1;
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  assign stall = (r_state == BUSY);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_en        <= 1'b0;
      r_write     <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_size      <= '0;
      r_lu        <= 1'b0;
      r_en_wb     <= 1'b0;
      r_use_pcp4  <= 1'b0;
      r_pcp4      <= '0;
      r_reg_write <= '0;
      r_cnt       <= '0;
    end else begin
      if (r_state == IDLE) begin
        r_en        <= en;
        r_write     <= write;
        r_addr      <= addr;
        r_wdata     <= write_data;
        r_size      <= size;
        r_lu        <= load_unsigned;
        r_en_wb     <= en_wb;
        r_use_pcp4  <= use_pcp4;
        r_pcp4      <= pcp4;
        r_reg_write <= reg_write;
      end
      if (w_start)                r_cnt <= 4'(WAIT - 1);
      else if (r_state == BUSY)   r_cnt <= r_cnt - 4'd1;
    end
  end

  // Gating on rst keeps a store from landing when reset is held across the edge.
  assign w_mem_we = w_complete && w_en && w_write && w_legal && !rst;

  always_ff @(posedge clk) begin
    if (w_mem_we) begin
      for (int unsigned b = 0; b < 4; b++) begin
        if (w_be[b]) r_mem[w_idx][8*b +: 8] <= w_lane[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      read_data     <= '0;
      en_wb_out     <= 1'b0;
      use_pcp4_out  <= 1'b0;
      pcp4_out      <= '0;
      reg_write_out <= '0;
      valid_out     <= 1'b0;
      fault         <= 1'b0;
    end else begin
      valid_out <= w_complete;
      fault     <= w_complete && w_en && !w_legal;
      if (w_complete) begin
        use_pcp4_out  <= w_use_pcp4;
        pcp4_out      <= w_pcp4;
        reg_write_out <= w_reg_write;
        en_wb_out     <= w_en_wb && !(w_en && !w_legal);
        if (!w_en)                   read_data <= w_addr;
        else if (!w_legal || w_write) read_data <= '0;
        else                         read_data <= w_load;
      end
    end
  end

endmodule

// File: tb/tb_mem_stage_ws.sv
// Bench for mem_stage_ws: three instances (WAIT=0,3,4) share one request stream and are
// compared every cycle against a byte-addressed reference model with per-instance latency.
module tb_mem_stage_ws;

  localparam int ND    = 3;
  localparam int DEPTH = 64;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en, write, load_unsigned, en_wb, use_pcp4;
  logic [31:0] addr, write_data, pcp4;
  logic [1:0]  size;
  logic [4:0]  reg_write;

  logic [31:0] rd [ND];
  logic [31:0] pco[ND];
  logic [4:0]  rwo[ND];
  logic        ewo[ND], upo[ND], vo[ND], st[ND], ft[ND];

  always #5 clk = ~clk;

  for (genvar g = 0; g < ND; g++) begin : g_dut
    mem_stage_ws #(.XLEN(32), .DEPTH(DEPTH), .WAIT(g == 0 ? 0 : g + 2)) u_dut (
      .clk(clk), .rst(rst), .en(en), .write(write), .addr(addr), .write_data(write_data),
      .size(size), .load_unsigned(load_unsigned), .en_wb(en_wb), .use_pcp4(use_pcp4),
      .pcp4(pcp4), .reg_write(reg_write), .read_data(rd[g]), .en_wb_out(ewo[g]),
      .use_pcp4_out(upo[g]), .pcp4_out(pco[g]), .reg_write_out(rwo[g]),
      .valid_out(vo[g]), .stall(st[g]), .fault(ft[g])
    );
  end

  function automatic int wt(int d);
    return (d == 0) ? 0 : d + 2;
  endfunction

  typedef struct {
    bit          en, write, lu, en_wb, upc;
    logic [31:0] addr, wdata, pcp4;
    logic [1:0]  size;
    logic [4:0]  rw;
  } req_t;

  logic [31:0] mm[ND][DEPTH];
  req_t        m_req [ND];
  bit          m_busy[ND];
  int          m_due [ND];
  int          cyc;
  logic [31:0] e_rd[ND], e_pc[ND];
  logic [4:0]  e_rw[ND];
  bit          e_ewb[ND], e_upc[ND], e_v[ND], e_f[ND];

  bit          got[ND], cap_f[ND], cap_ewb[ND];
  logic [31:0] cap_rd[ND], cap_pc[ND];
  logic [4:0]  cap_rw[ND];
  int          stcnt[ND];
  logic [31:0] last_pc;
  logic [4:0]  last_rw;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got_v, input logic [31:0] exp_v);
    n_cmp++;
    if (got_v !== exp_v) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got_v, exp_v, $time);
    end
  endtask

  function automatic bit legal(req_t r);
    logic [31:0] nb;
    if (r.size == 2'd3) return 1'b0;
    nb = 32'd1 << r.size;
    return (r.addr % nb == 0) && (r.addr / 4 < DEPTH);
  endfunction

  task automatic complete(int d);
    req_t        r;
    int          nb;
    logic [31:0] a, v;
    int          sh;
    r        = m_req[d];
    e_v[d]   = 1'b1;
    e_pc[d]  = r.pcp4;
    e_upc[d] = r.upc;
    e_rw[d]  = r.rw;
    if (!r.en) begin
      e_rd[d] = r.addr; e_ewb[d] = r.en_wb; e_f[d] = 1'b0;
    end else if (!legal(r)) begin
      e_rd[d] = '0; e_ewb[d] = 1'b0; e_f[d] = 1'b1;
    end else begin
      e_f[d]   = 1'b0;
      e_ewb[d] = r.en_wb;
      nb       = 1 << r.size;
      v        = '0;
      for (int i = 0; i < nb; i++) begin
        a  = r.addr + 32'(i);
        sh = 8 * int'(a % 4);
        if (r.write)
          mm[d][a/4] = (mm[d][a/4] & ~(32'hFF << sh)) | (((r.wdata >> (8*i)) & 32'hFF) << sh);
        else
          v = v | (((mm[d][a/4] >> sh) & 32'hFF) << (8*i));
      end
      if (!r.write && !r.lu && nb < 4 && v[8*nb-1]) v = v | ~((32'h1 << (8*nb)) - 32'h1);
      e_rd[d] = r.write ? 32'h0 : v;
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < ND; d++) begin
      m_busy[d] = 1'b0;
      e_rd[d] = '0; e_pc[d] = '0; e_rw[d] = '0;
      e_ewb[d] = 1'b0; e_upc[d] = 1'b0; e_v[d] = 1'b0; e_f[d] = 1'b0;
    end
  endtask

  task automatic model_edge();
    cyc++;
    if (rst) return;
    for (int d = 0; d < ND; d++) begin
      e_v[d] = 1'b0;
      e_f[d] = 1'b0;
      if (m_busy[d]) begin
        if (cyc == m_due[d]) begin
          complete(d);
          m_busy[d] = 1'b0;
        end
      end else begin
        m_req[d] = '{en: en, write: write, lu: load_unsigned, en_wb: en_wb, upc: use_pcp4,
                     addr: addr, wdata: write_data, pcp4: pcp4, size: size, rw: reg_write};
        if (en && legal(m_req[d]) && wt(d) > 0) begin
          m_busy[d] = 1'b1;
          m_due[d]  = cyc + wt(d);
        end else begin
          complete(d);
        end
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    for (int d = 0; d < ND; d++) begin
      check($sformatf("stall%0d", d), 32'(st[d]), 32'(m_busy[d]));
      check($sformatf("valid%0d", d), 32'(vo[d]), 32'(e_v[d]));
      check($sformatf("fault%0d", d), 32'(ft[d]), 32'(e_f[d]));
      check($sformatf("rdata%0d", d), rd[d], e_rd[d]);
      check($sformatf("enwb%0d", d), 32'(ewo[d]), 32'(e_ewb[d]));
      check($sformatf("upc%0d", d), 32'(upo[d]), 32'(e_upc[d]));
      check($sformatf("pcp4_%0d", d), pco[d], e_pc[d]);
      check($sformatf("regw%0d", d), 32'(rwo[d]), 32'(e_rw[d]));
      if (!got[d]) begin
        if (st[d]) stcnt[d]++;
        if (vo[d]) begin
          got[d] = 1'b1; cap_rd[d] = rd[d]; cap_f[d] = ft[d]; cap_ewb[d] = ewo[d];
          cap_pc[d] = pco[d]; cap_rw[d] = rwo[d];
        end
      end
    end
  endtask

  task automatic idle_all();
    int k;
    en = 1'b0;
    k  = 0;
    while ((st[0] || st[1] || st[2]) && k < 12) begin
      tick();
      k++;
    end
    if (st[0] || st[1] || st[2]) check("idle_timeout", 32'd1, 32'd0);
  endtask

  task automatic op(input bit e, input bit w, input logic [31:0] a, input logic [31:0] wd,
                    input logic [1:0] sz, input bit lu);
    en = e; write = w; addr = a; write_data = wd; size = sz; load_unsigned = lu;
    en_wb = 1'b1; use_pcp4 = 1'($urandom); pcp4 = $urandom; reg_write = 5'($urandom);
    last_pc = pcp4; last_rw = reg_write;
    for (int d = 0; d < ND; d++) begin got[d] = 1'b0; stcnt[d] = 0; end
    tick();
    idle_all();
  endtask

  task automatic check_all_zero(input string tag);
    for (int d = 0; d < ND; d++) begin
      check($sformatf("%s_rd%0d", tag, d), rd[d], 32'h0);
      check($sformatf("%s_ctl%0d", tag, d),
            {25'd0, ewo[d], upo[d], vo[d], st[d], ft[d], 2'd0}, 32'h0);
      check($sformatf("%s_pc%0d", tag, d), pco[d] | 32'(rwo[d]), 32'h0);
    end
  endtask

  initial begin
    en = 1'b0; write = 1'b0; addr = '0; write_data = '0; size = '0; load_unsigned = 1'b0;
    en_wb = 1'b0; use_pcp4 = 1'b0; pcp4 = '0; reg_write = '0; cyc = 0;
    model_reset();
    #1;
    check_all_zero("reset");
    repeat (2) tick();
    rst = 1'b0;

    for (int w = 0; w < DEPTH; w++) op(1, 1, 32'(w * 4), $urandom, 2'd2, 0);

    op(1, 1, 32'h10, 32'hDEADBEEF, 2'd2, 0);
    check("sw_w0_stall", 32'(stcnt[0]), 0);
    op(1, 0, 32'h10, 32'h0, 2'd2, 0);
    for (int d = 0; d < ND; d++) check($sformatf("lw_dead%0d", d), cap_rd[d], 32'hDEADBEEF);

    op(1, 1, 32'h10, 32'h0000_80FF, 2'd2, 0);
    op(1, 0, 32'h11, 32'h0, 2'd0, 0);
    for (int d = 0; d < ND; d++) check($sformatf("lb_s%0d", d), cap_rd[d], 32'hFFFFFF80);
    check("lb_stall3", 32'(stcnt[1]), 3);
    check("lb_stall4", 32'(stcnt[2]), 4);
    check("lb_regw", 32'(cap_rw[1]), 32'(last_rw));
    check("lb_pcp4", cap_pc[1], last_pc);
    op(1, 0, 32'h11, 32'h0, 2'd0, 1);
    for (int d = 0; d < ND; d++) check($sformatf("lbu%0d", d), cap_rd[d], 32'h00000080);

    op(1, 1, 32'h10, 32'h0, 2'd2, 0);
    op(1, 1, 32'h14, 32'h0, 2'd2, 0);
    op(1, 1, 32'h12, 32'hFFFF_FFAA, 2'd0, 0);
    op(1, 1, 32'h14, 32'hFFFF_1234, 2'd1, 0);
    op(1, 0, 32'h10, 32'h0, 2'd2, 0);
    for (int d = 0; d < ND; d++) check($sformatf("sb_word%0d", d), cap_rd[d], 32'h00AA0000);
    op(1, 0, 32'h14, 32'h0, 2'd2, 0);
    for (int d = 0; d < ND; d++) check($sformatf("sh_word%0d", d), cap_rd[d], 32'h00001234);

    begin
      bit          fw [7] = '{0, 0, 0, 0, 1, 1, 1};
      logic [31:0] fa [7] = '{32'h13, 32'h12, 32'h10, DEPTH * 4, 32'h11, 32'h10, 32'h16};
      logic [1:0]  fs [7] = '{2'd1, 2'd2, 2'd3, 2'd2, 2'd1, 2'd3, 2'd2};
      for (int i = 0; i < 7; i++) begin
        op(1, fw[i], fa[i], 32'h5A5A_5A5A, fs[i], 0);
        for (int d = 0; d < ND; d++) begin
          check($sformatf("flt%0d_f%0d", i, d), 32'(cap_f[d]), 32'd1);
          check($sformatf("flt%0d_wb%0d", i, d), 32'(cap_ewb[d]), 32'd0);
          check($sformatf("flt%0d_rd%0d", i, d), cap_rd[d], 32'h0);
          check($sformatf("flt%0d_st%0d", i, d), 32'(stcnt[d]), 32'd0);
        end
      end
    end
    op(1, 0, 32'h10, 32'h0, 2'd2, 0);
    check("flt_ram10", cap_rd[2], 32'h00AA0000);
    op(1, 0, 32'h14, 32'h0, 2'd2, 0);
    check("flt_ram14", cap_rd[2], 32'h00001234);

    op(0, 0, 32'h1234_5678, 32'h0, 2'd0, 0);
    for (int d = 0; d < ND; d++) begin
      check($sformatf("pass_rd%0d", d), cap_rd[d], 32'h12345678);
      check($sformatf("pass_pc%0d", d), cap_pc[d], last_pc);
      check($sformatf("pass_rw%0d", d), 32'(cap_rw[d]), 32'(last_rw));
      check($sformatf("pass_wb%0d", d), 32'(cap_ewb[d]), 32'd1);
    end

    op(1, 1, 32'h20, 32'hCAFE_F00D, 2'd2, 0);
    en = 1'b1; write = 1'b1; addr = 32'h20; write_data = 32'h55; size = 2'd2;
    tick();
    en = 1'b0;
    tick();
    rst = 1'b1;
    #1;
    model_reset();
    check_all_zero("abort");
    tick();
    rst = 1'b0;
    op(1, 0, 32'h20, 32'h0, 2'd2, 0);
    check("abort_w0", cap_rd[0], 32'h00000055);
    check("abort_w3", cap_rd[1], 32'hCAFEF00D);
    check("abort_w4", cap_rd[2], 32'hCAFEF00D);

    for (int n = 0; n < 2000; n++) begin
      en = 1'($urandom); write = 1'($urandom); load_unsigned = 1'($urandom);
      en_wb = 1'($urandom); use_pcp4 = 1'($urandom); pcp4 = $urandom;
      reg_write = 5'($urandom); write_data = $urandom; size = 2'($urandom_range(0, 3));
      addr = ($urandom_range(0, 9) == 0) ? $urandom : 32'($urandom_range(0, DEPTH * 4 + 15));
      tick();
    end
    idle_all();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
